popcount_seq: RTL and testbench
===============================

Name: popcount_seq

Overview:
- Parametrised, multi-cycle population counter with valid/ready handshakes on input and output.
- Processes an N-bit word CHUNK bits per cycle, trading latency for adder depth.
- Counts ones or zeros, selected per transaction.
- Result width is sized to hold the full count N, with no overflow at all-ones.
- Sits between datapath producers and status/statistics logic that need bit counts.

Parameters:
- N, 32: input word width; N >= 2.
- CHUNK, 8: bits counted per cycle; must divide N; 1 <= CHUNK <= N.
- Derived localparam OW = $clog2(N+1): output count width (6 for N=32).
- Derived localparam BEATS = N/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  block can accept a word.
- in_data  in  N  word to count.
- in_mode  in  1  0 = count ones, 1 = count zeros; sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_count  out  OW  count result.
- out_full  out  1  high when out_count == N.

Behaviour:
- Reset is synchronous: on a clk edge with rst=1 the block enters IDLE.
  - out_valid=0, out_count=0, out_full=0, accumulator=0, beat counter=0, shift register=0.
  - in_ready=1 from the first cycle after reset is released.
- States: IDLE, BUSY, DONE, held in an enum.
- in_ready=1 only in IDLE. Combinational from state only; never depends on in_valid.
- IDLE:
  - On in_valid && in_ready, capture the shift register = in_mode ? ~in_data : in_data.
  - Clear the accumulator and beat counter; go to BUSY.
- BUSY, each cycle:
  - accumulator += popcount(shift[CHUNK-1:0]).
  - shift >>= CHUNK.
  - beat counter += 1.
  - On the cycle that completes beat BEATS-1, go to DONE. out_count is loaded with the final sum on that same edge.
- DONE:
  - out_valid=1; out_count and out_full are stable and unchanged while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid falls next cycle. out_count holds its last value.
- Latency: accept edge to out_valid high = BEATS cycles (4 for N=32, CHUNK=8).
- Throughput: one word per BEATS+2 cycles with out_ready tied high.
- Arithmetic: the accumulator is OW bits and cannot overflow, since the maximum sum is N. The per-chunk popcount is $clog2(CHUNK+1) bits, zero-extended to OW.
- CHUNK == N: BUSY lasts exactly one cycle.
- in_valid asserted while BUSY/DONE: ignored, not captured. The producer must hold the word until in_ready.
- in_data/in_mode changes after acceptance: no effect.
- Reset mid-BUSY or mid-DONE: the result is discarded; same values as reset above; no stale out_valid.

Optional Feature:
- Macro: POPCNT_EARLY_EXIT_EN.
- Defined:
  - In BUSY, if the shift register is all-zero at the start of a cycle, go to DONE on that edge with the accumulator unchanged.
  - Latency becomes variable, 1..BEATS cycles.
  - An input word of 0 in ones mode gives out_valid 1 cycle after acceptance.
- Undefined: latency is always exactly BEATS cycles.
- Results are identical either way.

Decomposition:
- Package popcount_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE);
  - the mode constants MODE_ONES=1'b0 and MODE_ZEROS=1'b1.
- Sub-module popcount_chunk #(W): combinational popcount of W bits, output $clog2(W+1) bits.
  - Instantiated once with W=CHUNK.
  - Reusable by other blocks.

Test Plan (N=32, CHUNK=8, out_ready=1 unless stated):
- Sweep in_data = 1<<i for i=0..31, mode ones -> out_count=1 every word; out_valid exactly 4 cycles after each accept.
- in_data=32'hFFFF_FFFF, mode ones -> out_count=32, out_full=1 (checks the OW=6 width). Same word in mode zeros -> out_count=0, out_full=0.
- in_data=32'h0000_00FF, mode zeros -> out_count=24. Then in_data=32'hA5A5_A5A5, mode ones -> 16.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> out_count stable, in_ready=0, extra in_valid words not captured. Release -> next word accepted after IDLE is reached.
- Assert rst for 1 cycle during BUSY beat 2 -> next cycle out_valid=0, out_count=0, in_ready=1. The following word 32'h0000_000F gives 4.
- With POPCNT_EARLY_EXIT_EN: in_data=32'h0000_0001, mode ones -> out_count=1 after 2 cycles. in_data=0 -> out_count=0 after 1 cycle. Without the macro, both take 4 cycles.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential popcount block.
package popcount_pkg;

    // Controller states of popcount_seq.
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Per-transaction counting mode, sampled alongside the data word.
    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

endpackage : popcount_pkg

// File: rtl/popcount_chunk.sv
// Combinational population count of a W-bit slice.
// The result is $clog2(W+1) bits wide, so the all-ones case (W) fits.
module popcount_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]          i_bits,
    output logic [$clog2(W+1)-1:0] o_count
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] w_sum;

    // Sum every bit of the slice.
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < W; i++) begin
            w_sum = w_sum + CW'(i_bits[i]);
        end
    end

    assign o_count = w_sum;

endmodule : popcount_chunk

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts ones (or zeros) of an N-bit word,
// CHUNK bits per cycle, with valid/ready handshakes on both sides.
// Optional macro POPCNT_EARLY_EXIT_EN: finish as soon as the remaining
// shift register is all-zero (variable latency, identical results).
module popcount_seq
    import popcount_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_data,
    input  logic                    in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N+1)-1:0]  out_count,
    output logic                    out_full
);

    localparam int unsigned OW    = $clog2(N + 1);
    localparam int unsigned CW    = $clog2(CHUNK + 1);
    localparam int unsigned BEATS = N / CHUNK;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t          r_state;
    logic [N-1:0]    r_shift;
    logic [OW-1:0]   r_acc;
    logic [BW-1:0]   r_beat;
    logic            r_valid;
    logic [OW-1:0]   r_count;
    logic            r_full;

    logic [CW-1:0]   w_chunk_cnt;
    logic [OW-1:0]   w_sum;
    logic            w_last;

    popcount_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .i_bits  (r_shift[CHUNK-1:0]),
        .o_count (w_chunk_cnt)
    );

    assign w_sum  = r_acc + OW'(w_chunk_cnt);
    assign w_last = (r_beat == BW'(BEATS - 1));

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_valid;
    assign out_count = r_count;
    assign out_full  = r_full;

    // Controller, datapath accumulation and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_beat  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= (in_mode == MODE_ZEROS) ? ~in_data : in_data;
                        r_acc   <= '0;
                        r_beat  <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
`ifdef POPCNT_EARLY_EXIT_EN
                    if (r_shift == '0) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_count <= r_acc;
                        r_full  <= (r_acc == OW'(N));
                    end else
`endif
                    begin
                        r_acc   <= w_sum;
                        r_shift <= r_shift >> CHUNK;
                        r_beat  <= r_beat + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                            r_count <= w_sum;
                            r_full  <= (w_sum == OW'(N));
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : popcount_seq

// File: tb/tb_popcount_seq.sv
// Directed self-checking bench for popcount_seq (N=32, CHUNK=8).
module tb_popcount_seq;
    import popcount_pkg::*;

    localparam int unsigned N     = 32;
    localparam int unsigned CHUNK = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_count;
    logic        out_full;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    popcount_seq #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_full  (out_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected accept-to-valid latency for the word actually shifted.
    function automatic int unsigned exp_lat(input logic [31:0] w);
`ifdef POPCNT_EARLY_EXIT_EN
        int unsigned last;
        if (w == 32'h0) return 1;
        last = 0;
        for (int unsigned j = 0; j < 4; j++)
            if (((w >> (8 * j)) & 32'hFF) != 0) last = j;
        return (last + 2 > 4) ? 4 : last + 2;
`else
        return 4 + 0 * w[0];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (in_ready) break;
            step();
        end
        chk({tag, "_rdy"}, in_ready, 1);
    endtask

    // Send one word; check count, full flag and latency. With hold set, keep
    // out_ready low for 6 cycles and try to inject extra words meanwhile.
    task automatic run_word(input string tag, input logic [31:0] d, input logic m,
                            input int unsigned exp_cnt, input bit hold);
        int unsigned lat;
        logic [31:0] eff;
        eff = (m == MODE_ZEROS) ? ~d : d;
        out_ready = ~hold;
        wait_ready(tag);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        step();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_mode  = ~m;
        lat = 20;
        for (int unsigned c = 1; c <= 20; c++) begin
            step();
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat(eff));
        chk({tag, "_cnt"}, out_count, exp_cnt);
        chk({tag, "_full"}, out_full, (exp_cnt == 32) ? 1 : 0);
        if (hold) begin
            for (int k = 0; k < 6; k++) begin
                in_valid = 1'b1;
                in_data  = 32'hFFFF_FFFF;
                in_mode  = MODE_ONES;
                step();
                chk({tag, "_hold_cnt"}, out_count, exp_cnt);
                chk({tag, "_hold_vld"}, out_valid, 1);
                chk({tag, "_hold_rdy"}, in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        step();
        chk({tag, "_vld_drop"}, out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = MODE_ONES;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_vld", out_valid, 0);
        chk("rst_cnt", out_count, 0);
        chk("rst_full", out_full, 0);
        chk("rst_rdy", in_ready, 1);

        for (int unsigned i = 0; i < 32; i++)
            run_word($sformatf("walk%0d", i), 32'h1 << i, MODE_ONES, 1, 0);

        run_word("ones_all",  32'hFFFF_FFFF, MODE_ONES,  32, 0);
        run_word("zeros_all", 32'hFFFF_FFFF, MODE_ZEROS, 0,  0);
        run_word("zeros_ff",  32'h0000_00FF, MODE_ZEROS, 24, 0);
        run_word("ones_a5",   32'hA5A5_A5A5, MODE_ONES,  16, 0);

        // Backpressure, then a fresh word must give its own count.
        run_word("bp",       32'h0000_00FF, MODE_ONES, 8, 1);
        run_word("after_bp", 32'h0000_0003, MODE_ONES, 2, 0);

        // Reset during BUSY beat 2 discards the result.
        wait_ready("mid_rst");
        in_valid = 1'b1;
        in_data  = 32'h7777_7777;
        in_mode  = MODE_ONES;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_cnt", out_count, 0);
        chk("mid_rst_full", out_full, 0);
        chk("mid_rst_rdy", in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_rst_stale", out_valid, 0);
        end
        run_word("post_rst", 32'h0000_000F, MODE_ONES, 4, 0);

        // Early-exit latency cases (fixed 4 cycles without the macro).
        run_word("ee_one",  32'h0000_0001, MODE_ONES, 1, 0);
        run_word("ee_zero", 32'h0000_0000, MODE_ONES, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_popcount_seq
